// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap/mret status, interrupt enables and pending,
// trap vectoring, and 64-bit performance counters with inhibit control.
module csr_unit #(
   parameter int XLEN    = 32,
   parameter int NUM_HPM = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_din,
   output logic [XLEN-1:0]    csr_dout,
   output logic               csr_illegal,
   input  logic               instret,
   input  logic [NUM_HPM-1:0] hpm_evt,
   input  logic               trap_req,
   input  logic [XLEN-1:0]    trap_cause,
   input  logic [XLEN-1:0]    trap_pc,
   input  logic [XLEN-1:0]    trap_val,
   input  logic               mret,
   input  logic               sw_irq,
   input  logic               tmr_irq,
   input  logic               ext_irq,
   output logic [XLEN-1:0]    trap_vector,
   output logic [XLEN-1:0]    epc,
   output logic               irq_pending
);
   localparam int NCNT = NUM_HPM + 2;
   localparam int IW   = (NCNT > 1) ? $clog2(NCNT) : 1;
   localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(12'h888);
   localparam logic [XLEN-1:0] MISA = (XLEN'((XLEN == 32) ? 1 : 2) << (XLEN - 2)) | XLEN'(9'h100);
   // inhibit bits exist for cycle (0), instret (2) and each hpm counter; bit 1 is hardwired 0
   localparam logic [31:0] INH_MASK = 32'(((64'd1 << (NUM_HPM + 3)) - 64'd1) & ~64'h2);

   logic                  mie_b, mpie_b;
   logic [XLEN-1:0]       mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
   logic [31:0]           inh_r;
   logic [NCNT-1:0][63:0] cnt;

   logic [XLEN-1:0] mstatus_v, mip_v, rdata, wval;
   logic            hit, eff, wen, cnt_hit, cnt_hi;
   logic [IW-1:0]   cidx;
   logic [NCNT-1:0] ev, inh_c;
   logic [63:0]     cnew;
   logic            unused;

   assign unused = ^{trap_pc[0], trap_cause[XLEN-2]};

   assign mstatus_v = XLEN'({2'b11, 3'b000, mpie_b, 3'b000, mie_b, 3'b000});
   assign mip_v     = XLEN'({ext_irq, 3'b000, tmr_irq, 3'b000, sw_irq, 3'b000});
   assign ev        = {hpm_evt, instret, 1'b1};

   for (genvar g = 0; g < NCNT; g++) begin : g_inh
      assign inh_c[g] = inh_r[(g == 0) ? 0 : g + 1];
   end

   // Counter address decode: Bxx low halves, B8x high halves (XLEN=32 only)
   always_comb begin
      cnt_hit = 1'b0;
      cnt_hi  = csr_addr[7];
      cidx    = '0;
      if (csr_addr[11:8] == 4'hB && csr_addr[6:5] == 2'b00 && (!csr_addr[7] || XLEN == 32)) begin
         if (csr_addr[4:0] == 5'd0) begin
            cnt_hit = 1'b1;
         end else if (csr_addr[4:0] == 5'd2) begin
            cnt_hit = 1'b1;
            cidx    = IW'(1);
         end else if (csr_addr[4:0] >= 5'd3 && int'(csr_addr[4:0]) <= NUM_HPM + 2) begin
            cnt_hit = 1'b1;
            cidx    = IW'(csr_addr[4:0] - 5'd1);
         end
      end
   end

   always_comb begin
      rdata = '0;
      hit   = 1'b1;
      case (csr_addr)
         12'hF11, 12'hF12, 12'hF13, 12'hF14: rdata = '0;
         12'h300: rdata = mstatus_v;
         12'h301: rdata = MISA;
         12'h304: rdata = mie_r;
         12'h305: rdata = mtvec_r;
         12'h320: rdata = XLEN'(inh_r);
         12'h340: rdata = mscratch_r;
         12'h341: rdata = mepc_r;
         12'h342: rdata = mcause_r;
         12'h343: rdata = mtval_r;
         12'h344: rdata = mip_v;
         default: begin
            hit = cnt_hit;
            if (cnt_hit)
               rdata = cnt_hi ? XLEN'(cnt[cidx][63:32]) : cnt[cidx][XLEN-1:0];
         end
      endcase
   end

   always_comb begin
      case (csr_op)
         2'b10:   wval = rdata | csr_din;
         2'b11:   wval = rdata & ~csr_din;
         default: wval = csr_din;
      endcase
   end

   always_comb begin
      cnew = cnt[cidx];
      if (XLEN == 64)  cnew        = 64'(wval);
      else if (cnt_hi) cnew[63:32] = wval[31:0];
      else             cnew[31:0]  = wval[31:0];
   end

   assign csr_dout    = rdata;
   assign eff         = (csr_op == 2'b01) || (csr_op != 2'b00 && csr_din != '0);
   assign csr_illegal = (csr_op != 2'b00) && (!hit || (eff && csr_addr[11:10] == 2'b11));
   assign wen         = eff && !csr_illegal && !trap_req && !mret;

   assign trap_vector = (mtvec_r[1:0] == 2'b01 && trap_cause[XLEN-1])
                      ? {mtvec_r[XLEN-1:2], 2'b00} + {trap_cause[XLEN-3:0], 2'b00}
                      : {mtvec_r[XLEN-1:2], 2'b00};
   assign epc         = mepc_r;
   assign irq_pending = mie_b && |(mip_v & mie_r);

   function automatic logic cause_ok(input logic [XLEN-1:0] c);
      logic [3:0] code;
      code = c[3:0];
      if (c[XLEN-2:4] != '0) return 1'b0;
      if (c[XLEN-1]) return code[0] && code <= 4'd11;
      return code <= 4'd9 || code == 4'd11 || code == 4'd12 || code == 4'd13 || code == 4'd15;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_b      <= 1'b0;
         mpie_b     <= 1'b0;
         mie_r      <= '0;
         mtvec_r    <= '0;
         mscratch_r <= '0;
         mepc_r     <= '0;
         mcause_r   <= '0;
         mtval_r    <= '0;
         inh_r      <= '0;
      end else if (trap_req) begin
         mepc_r   <= {trap_pc[XLEN-1:1], 1'b0};
         mcause_r <= trap_cause;
         mtval_r  <= trap_val;
         mpie_b   <= mie_b;
         mie_b    <= 1'b0;
      end else if (mret) begin
         mie_b  <= mpie_b;
         mpie_b <= 1'b1;
      end else if (wen) begin
         case (csr_addr)
            12'h300: begin
               mie_b  <= wval[3];
               mpie_b <= wval[7];
            end
            12'h304: mie_r      <= wval & IRQ_MASK;
            12'h305: mtvec_r    <= {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
            12'h320: inh_r      <= wval[31:0] & INH_MASK;
            12'h340: mscratch_r <= wval;
            12'h341: mepc_r     <= {wval[XLEN-1:1], 1'b0};
            12'h342: if (cause_ok(wval)) mcause_r <= wval;
            12'h343: mtval_r    <= wval;
            default: ;
         endcase
      end
   end

   // A software write to either half wins over that cycle's increment
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCNT; i++) begin
         if (rst)                                     cnt[i] <= '0;
         else if (wen && cnt_hit && cidx == IW'(i))   cnt[i] <= cnew;
         else if (ev[i] && !inh_c[i])                 cnt[i] <= cnt[i] + 64'd1;
      end
   end
endmodule
